// File: rtl/fa_dcache_ctrl.sv
// fa_dcache_ctrl: fully associative write-back, write-allocate data cache with LRU replacement
module fa_dcache_ctrl #(
  parameter int NUM_LINES  = 4,
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                            Clk,
  input  logic                            reset_n,
  input  logic                            c_readM,
  input  logic                            c_writeM,
  input  logic [15:0]                     c_address,
  input  logic [WORD_SIZE-1:0]            c_wdata,
  output logic [WORD_SIZE-1:0]            c_rdata,
  output logic                            c_wait,
  output logic                            m_readM,
  output logic                            m_writeM,
  output logic [15:0]                     m_address,
  output logic [WORD_SIZE*LINE_WORDS-1:0] m_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] m_rdata,
  input  logic                            m_ready,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     access_count
);
  localparam int AW = $clog2(NUM_LINES);
  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
  state_t state_q;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [13:0] tag_q [NUM_LINES];
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] data_q [NUM_LINES];
  logic [AW-1:0] age_q [NUM_LINES];
  logic [AW-1:0] vic_q, hit_idx, vic;
  logic [15:0] hit_q, acc_q, m_address_q;
  logic [WORD_SIZE*LINE_WORDS-1:0] m_wdata_q;
  logic m_readM_q, m_writeM_q, missed_q, req, hit, done, inv_any;
  always_comb begin
    req = c_readM | c_writeM;
    hit = 1'b0;
    hit_idx = '0;
    vic = '0;
    inv_any = 1'b0;
    for (int i = 0; i < NUM_LINES; i++)
      if (valid_q[i] && tag_q[i] == c_address[15:2]) begin
        hit = req;
        hit_idx = AW'(i);
      end
    // lowest-index free line wins; otherwise the oldest line is replaced
    for (int i = NUM_LINES - 1; i >= 0; i--)
      if (!valid_q[i]) begin
        inv_any = 1'b1;
        vic = AW'(i);
      end
    if (!inv_any)
      for (int i = 0; i < NUM_LINES; i++)
        if (age_q[i] == AW'(NUM_LINES - 1)) vic = AW'(i);
    done = state_q == IDLE && hit;
    c_wait = req && !done;
    c_rdata = done ? data_q[hit_idx][c_address[1:0]] : '0;
  end
  assign m_readM = m_readM_q;
  assign m_writeM = m_writeM_q;
  assign m_address = m_address_q;
  assign m_wdata = m_wdata_q;
  assign hit_count = hit_q;
  assign access_count = acc_q;
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      m_readM_q <= 1'b0;
      m_writeM_q <= 1'b0;
      m_address_q <= '0;
      m_wdata_q <= '0;
      hit_q <= '0;
      acc_q <= '0;
      missed_q <= 1'b0;
      vic_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) age_q[i] <= AW'(i);
    end else begin
      if (done) begin
        acc_q <= acc_q + 16'd1;
        hit_q <= missed_q ? hit_q : hit_q + 16'd1;
        missed_q <= 1'b0;
        for (int i = 0; i < NUM_LINES; i++)
          if (age_q[i] < age_q[hit_idx]) age_q[i] <= age_q[i] + 1'b1;
        age_q[hit_idx] <= '0;
        if (c_writeM) begin
          data_q[hit_idx][c_address[1:0]] <= c_wdata;
          dirty_q[hit_idx] <= 1'b1;
        end
      end
      case (state_q)
        IDLE:
          if (req && !hit) begin
            missed_q <= 1'b1;
            vic_q <= vic;
            if (valid_q[vic] && dirty_q[vic]) begin
              state_q <= WB;
              m_writeM_q <= 1'b1;
              m_address_q <= {tag_q[vic], 2'b00};
              m_wdata_q <= data_q[vic];
            end else begin
              state_q <= FILL;
              m_readM_q <= 1'b1;
              m_address_q <= {c_address[15:2], 2'b00};
            end
          end
        WB:
          if (m_ready) begin
            dirty_q[vic_q] <= 1'b0;
            m_writeM_q <= 1'b0;
            m_readM_q <= 1'b1;
            m_address_q <= {c_address[15:2], 2'b00};
            state_q <= FILL;
          end
        FILL:
          if (m_ready) begin
            m_readM_q <= 1'b0;
            state_q <= IDLE;
            data_q[vic_q] <= m_rdata;
            tag_q[vic_q] <= m_address_q[15:2];
            valid_q[vic_q] <= 1'b1;
            dirty_q[vic_q] <= 1'b0;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fa_dcache_ctrl.sv
// tb_fa_dcache_ctrl: randomized and directed bench against a flat-memory plus LRU-list reference model
module tb_fa_dcache_ctrl;
  localparam int NL = 4;
  logic Clk = 0, reset_n = 0, c_readM = 0, c_writeM = 0, m_ready = 0;
  logic [15:0] c_address = 0, c_wdata = 0, c_rdata, m_address, hit_count, access_count;
  logic c_wait, m_readM, m_writeM;
  logic [63:0] m_wdata, m_rdata = 0;
  int checks = 0, passed = 0, mem_lat = 2;
  logic [63:0] mem [0:16383];
  logic [15:0] shadow [0:65535];
  int lru_q[$];
  bit dty [int];
  int m_acc = 0, m_hit = 0;
  logic [79:0] wb_log[$];
  logic [15:0] fill_log[$];

  fa_dcache_ctrl #(.NUM_LINES(NL), .WORD_SIZE(16), .LINE_WORDS(4)) dut (
    .Clk(Clk), .reset_n(reset_n), .c_readM(c_readM), .c_writeM(c_writeM),
    .c_address(c_address), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_wait(c_wait),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .hit_count(hit_count), .access_count(access_count));

  always #5 Clk = ~Clk;

  // line memory with a programmable response latency
  initial begin
    int cnt = 0;
    forever begin
      @(negedge Clk);
      m_ready = 0;
      if (!reset_n || !(m_readM || m_writeM)) cnt = mem_lat;
      else if (cnt > 0) cnt--;
      else begin
        if (m_writeM) mem[m_address[15:2]] = m_wdata;
        else m_rdata = mem[m_address[15:2]];
        m_ready = 1;
        cnt = mem_lat;
      end
    end
  end

  always @(posedge Clk)
    if (reset_n && m_ready) begin
      if (m_writeM) wb_log.push_back({m_address, m_wdata});
      if (m_readM) fill_log.push_back(m_address);
    end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] line_of(input int t);
    return {shadow[t*4+3], shadow[t*4+2], shadow[t*4+1], shadow[t*4]};
  endfunction

  // cache is transparent over a flat word memory; presence follows a pure LRU list
  function automatic void model_access(input bit w, input logic [15:0] a, input logic [15:0] wd,
                                       output bit hit, output bit ev, output int et, output logic [15:0] rd);
    int t = int'(a[15:2]);
    int pos = -1;
    foreach (lru_q[i]) if (lru_q[i] == t) pos = i;
    hit = pos >= 0;
    ev = 0;
    et = 0;
    if (hit) lru_q.delete(pos);
    else if (lru_q.size() == NL) begin
      et = lru_q.pop_back();
      ev = dty.exists(et);
      if (ev) dty.delete(et);
    end
    lru_q.push_front(t);
    if (w) begin
      shadow[a] = wd;
      dty[t] = 1;
    end
    rd = shadow[a];
    m_acc++;
    if (hit) m_hit++;
  endfunction

  function automatic void model_reset();
    foreach (lru_q[i])
      if (dty.exists(lru_q[i]))
        for (int k = 0; k < 4; k++) shadow[lru_q[i]*4+k] = mem[lru_q[i]][16*k +: 16];
    lru_q.delete();
    dty.delete();
    m_acc = 0;
    m_hit = 0;
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    reset_n = 0;
    c_readM = 0;
    c_writeM = 0;
    repeat (2) @(negedge Clk);
    reset_n = 1;
    model_reset();
  endtask

  task automatic do_req(input bit r, input bit w, input logic [15:0] a, input logic [15:0] wd,
                        output bit hit, output logic [15:0] rd);
    int cyc = 0;
    @(negedge Clk);
    c_readM = r;
    c_writeM = w;
    c_address = a;
    c_wdata = wd;
    #1;
    hit = !c_wait;
    while (c_wait && cyc < 200) begin
      @(negedge Clk);
      #1;
      cyc++;
    end
    if (c_wait) begin
      checks++;
      $display("FAIL timeout: request at %h still stalled after %0d cycles", a, cyc);
    end
    rd = c_rdata;
    @(negedge Clk);
    c_readM = 0;
    c_writeM = 0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    reset_n = 0;
    repeat (2) @(negedge Clk);
    checks++; if (m_readM !== 1'b0) $display("FAIL reset_m_readM: got %b want 0", m_readM); else passed++;
    checks++; if (m_writeM !== 1'b0) $display("FAIL reset_m_writeM: got %b want 0", m_writeM); else passed++;
    checks++; if (access_count !== 16'd0) $display("FAIL reset_access: got %0d want 0", access_count); else passed++;
    checks++; if (hit_count !== 16'd0) $display("FAIL reset_hit: got %0d want 0", hit_count); else passed++;
    checks++; if (c_rdata !== 16'd0) $display("FAIL reset_rdata: got %h want 0", c_rdata); else passed++;
    checks++; if (c_wait !== 1'b0) $display("FAIL reset_wait_idle: got %b want 0", c_wait); else passed++;
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_cold_read();
    bit h, eh, ev;
    int et;
    logic [15:0] rd, er;
    mem[4] = 64'h4444_3333_2222_1111;
    for (int k = 0; k < 4; k++) shadow[16+k] = mem[4][16*k +: 16];
    fill_log.delete();
    model_access(0, 16'h0013, 0, eh, ev, et, er);
    do_req(1, 0, 16'h0013, 0, h, rd);
    checks++; if (h !== 1'b0) $display("FAIL cold_wait: first-cycle hit %b want 0", h); else passed++;
    checks++; if (fill_log.size() != 1 || fill_log[0] !== 16'h0010) $display("FAIL cold_fill_addr: fills %0d first %h want 0010", fill_log.size(), fill_log.size() ? fill_log[0] : 16'hxxxx); else passed++;
    checks++; if (rd !== 16'h4444) $display("FAIL cold_rdata: got %h want 4444", rd); else passed++;
    checks++; if (access_count !== 16'd1 || hit_count !== 16'd0) $display("FAIL cold_counts: acc %0d hit %0d want 1 0", access_count, hit_count); else passed++;
  endtask

  task automatic test_hit_read();
    bit h, eh, ev;
    int et;
    logic [15:0] rd, er;
    model_access(0, 16'h0011, 0, eh, ev, et, er);
    do_req(1, 0, 16'h0011, 0, h, rd);
    checks++; if (h !== 1'b1) $display("FAIL hit_same_cycle: hit %b want 1", h); else passed++;
    checks++; if (rd !== 16'h2222) $display("FAIL hit_rdata: got %h want 2222", rd); else passed++;
    checks++; if (access_count !== 16'd2 || hit_count !== 16'd1) $display("FAIL hit_counts: acc %0d hit %0d want 2 1", access_count, hit_count); else passed++;
  endtask

  task automatic test_writeback();
    bit h, eh, ev;
    int et;
    logic [15:0] rd, er;
    logic [15:0] addrs [4] = '{16'h0020, 16'h0030, 16'h0040, 16'h0050};
    model_access(1, 16'h0012, 16'hABCD, eh, ev, et, er);
    do_req(0, 1, 16'h0012, 16'hABCD, h, rd);
    checks++; if (h !== 1'b1) $display("FAIL wr_hit: hit %b want 1", h); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        wb_log.delete();
        fill_log.delete();
      end
      model_access(0, addrs[i], 0, eh, ev, et, er);
      do_req(1, 0, addrs[i], 0, h, rd);
    end
    checks++; if (wb_log.size() != 1 || wb_log[0] !== {16'h0010, 64'h4444_ABCD_2222_1111}) $display("FAIL wb_line: count %0d entry %h want 0010_4444abcd22221111", wb_log.size(), wb_log.size() ? wb_log[0] : 80'hx); else passed++;
    checks++; if (fill_log.size() != 1 || fill_log[0] !== 16'h0050) $display("FAIL wb_then_fill: count %0d addr %h want 0050", fill_log.size(), fill_log.size() ? fill_log[0] : 16'hxxxx); else passed++;
    checks++; if (h !== 1'b0 || rd !== er) $display("FAIL wb_miss_rdata: hit %b rd %h want 0 %h", h, rd, er); else passed++;
  endtask

  task automatic test_lru();
    bit h, eh, ev;
    int et;
    logic [15:0] rd, er;
    logic [15:0] seq [8] = '{16'h0100, 16'h0104, 16'h0108, 16'h010C, 16'h0100, 16'h0110, 16'h0100, 16'h0104};
    bit want [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    do_reset();
    foreach (seq[i]) begin
      model_access(0, seq[i], 0, eh, ev, et, er);
      do_req(1, 0, seq[i], 0, h, rd);
      if (i >= 4) begin
        checks++; if (h !== want[i]) $display("FAIL lru_step%0d: addr %h hit %b want %b", i, seq[i], h, want[i]); else passed++;
      end
    end
  endtask

  task automatic test_both_write();
    bit h, eh, ev;
    int et;
    logic [15:0] rd, er;
    model_access(0, 16'h0011, 0, eh, ev, et, er);
    do_req(1, 0, 16'h0011, 0, h, rd);
    model_access(1, 16'h0011, 16'h5555, eh, ev, et, er);
    do_req(1, 1, 16'h0011, 16'h5555, h, rd);
    checks++; if (h !== 1'b1) $display("FAIL both_hit: hit %b want 1", h); else passed++;
    model_access(0, 16'h0011, 0, eh, ev, et, er);
    do_req(1, 0, 16'h0011, 0, h, rd);
    checks++; if (rd !== 16'h5555 || h !== 1'b1) $display("FAIL both_readback: rd %h hit %b want 5555 1", rd, h); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    bit h, eh, ev;
    int et;
    logic [15:0] rd, er;
    mem_lat = 30;
    fill_log.delete();
    @(negedge Clk);
    c_readM = 1;
    c_address = 16'h0200;
    repeat (3) @(negedge Clk);
    #1;
    checks++; if (m_readM !== 1'b1 || m_address !== 16'h0200) $display("FAIL midfill_req: m_readM %b addr %h want 1 0200", m_readM, m_address); else passed++;
    reset_n = 0;
    @(negedge Clk);
    #1;
    checks++; if (m_readM !== 1'b0) $display("FAIL midfill_abort: m_readM %b want 0", m_readM); else passed++;
    checks++; if (access_count !== 16'd0 || hit_count !== 16'd0) $display("FAIL midfill_counts: acc %0d hit %0d want 0 0", access_count, hit_count); else passed++;
    checks++; if (c_wait !== 1'b1) $display("FAIL midfill_wait: c_wait %b want 1", c_wait); else passed++;
    reset_n = 1;
    c_readM = 0;
    model_reset();
    mem_lat = 2;
    model_access(0, 16'h0011, 0, eh, ev, et, er);
    do_req(1, 0, 16'h0011, 0, h, rd);
    checks++; if (h !== 1'b0 || rd !== er) $display("FAIL postreset_invalid: hit %b rd %h want 0 %h", h, rd, er); else passed++;
    model_access(0, 16'h0200, 0, eh, ev, et, er);
    do_req(1, 0, 16'h0200, 0, h, rd);
    checks++; if (h !== 1'b0 || rd !== er) $display("FAIL postreset_no_partial: hit %b rd %h want 0 %h", h, rd, er); else passed++;
    checks++; if (fill_log.size() != 2) $display("FAIL postreset_fills: got %0d want 2", fill_log.size()); else passed++;
  endtask

  task automatic test_random();
    bit h, eh, ev, r, w;
    int et, kind;
    logic [15:0] rd, er, a, wd;
    logic [79:0] exp_wb;
    for (int n = 0; n < 300; n++) begin
      mem_lat = $urandom_range(0, 4);
      a = 16'($urandom_range(0, 31));
      kind = $urandom_range(0, 3);
      r = kind != 2;
      w = kind >= 2;
      wd = 16'($urandom);
      model_access(w, a, wd, eh, ev, et, er);
      exp_wb = {16'(et * 4), line_of(et)};
      wb_log.delete();
      do_req(r, w, a, wd, h, rd);
      checks++; if (h !== eh) $display("FAIL rand_hit[%0d]: addr %h hit %b want %b", n, a, h, eh); else passed++;
      if (!w) begin
        checks++; if (rd !== er) $display("FAIL rand_rdata[%0d]: addr %h got %h want %h", n, a, rd, er); else passed++;
      end
      checks++; if (wb_log.size() != (ev ? 1 : 0) || (ev && wb_log[0] !== exp_wb)) $display("FAIL rand_wb[%0d]: count %0d entry %h want %0d %h", n, wb_log.size(), wb_log.size() ? wb_log[0] : 80'hx, ev, exp_wb); else passed++;
    end
    checks++; if (access_count !== 16'(m_acc)) $display("FAIL rand_access: got %0d want %0d", access_count, m_acc); else passed++;
    checks++; if (hit_count !== 16'(m_hit)) $display("FAIL rand_hits: got %0d want %0d", hit_count, m_hit); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++)
      for (int k = 0; k < 4; k++) begin
        shadow[i*4+k] = 16'(i * 5 + k * 17) ^ 16'h3C00;
        mem[i][16*k +: 16] = shadow[i*4+k];
      end
    test_reset();
    test_cold_read();
    test_hit_read();
    test_writeback();
    test_lru();
    test_both_write();
    test_reset_mid_fill();
    do_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fa_dcache_ctrl.md
Name: fa_dcache_ctrl

Overview:
- Fully associative, write-back, write-allocate data cache between the pipelined CPU's MEM stage and line-wide data memory.
- Accepts word reads/writes from the CPU. Asserts c_wait while a miss is serviced; the CPU's virtual clock freezes the pipeline during that time.
- Fetches and evicts whole 4-word lines over a request/ready memory handshake.
- Keeps hit and access counters for cache-performance reporting.

Parameters:
- NUM_LINES, 4, number of cache lines (power of two, 2..8).
- WORD_SIZE, 16, CPU word width in bits.
- LINE_WORDS, 4, words per line (fixed; offset = address[1:0]).

Ports:
- Clk  input  1  clock
- reset_n  input  1  reset, synchronous, active-low
- c_readM  input  1  CPU read request, held stable until c_wait low
- c_writeM  input  1  CPU write request, held stable until c_wait low
- c_address  input  16  CPU word address
- c_wdata  input  16  CPU write data
- c_rdata  output  16  read data, valid when c_readM && !c_wait
- c_wait  output  1  stall; high while a request cannot complete this cycle
- m_readM  output  1  memory line read request
- m_writeM  output  1  memory line write request
- m_address  output  16  line base address (low 2 bits zero)
- m_wdata  output  64  eviction line data
- m_rdata  input  64  fill line data, valid when m_ready
- m_ready  input  1  one-cycle pulse: memory finished the current request
- hit_count  output  16  completed requests that hit on first lookup
- access_count  output  16  completed requests

Behaviour:
- Per-line state: valid, dirty, tag = address[15:2], 4 data words, LRU age (log2 NUM_LINES bits).
- Word w of a line is line_data[16*w+15 : 16*w].
- Reset, on a Clk edge with reset_n=0:
  - all valid/dirty cleared; age[i]=i; state=IDLE
  - m_readM=m_writeM=0, counters=0, missed=0, c_rdata=0
  - reset aborts any in-progress fill or writeback immediately; no partial line is installed.
- Request = c_readM|c_writeM. If both are asserted, it is treated as a write.
- Hit detection is combinational in IDLE: hit = request && any valid line with tag == c_address[15:2].
- c_wait = request && !(state==IDLE && hit).
- Read hit: c_rdata = hit word, combinational, same cycle.
- Write hit: word and dirty=1 updated at the next Clk edge.
- Each request completion (request && !c_wait at a Clk edge):
  - access_count+1
  - hit_count+1 only if missed==0
  - missed cleared
  - LRU touch: hit line age←0; every line whose age < old age increments. Other ages unchanged.
- State machine:
  - IDLE:
    - request && !hit → set missed=1 and pick a victim: lowest-index invalid line, else the line with age NUM_LINES-1.
    - Dirty victim → WB; clean or invalid victim → FILL.
  - WB:
    - m_writeM=1, m_address={victim tag,2'b00}, m_wdata=victim data.
    - On m_ready: clear dirty → FILL.
  - FILL:
    - m_readM=1, m_address={c_address[15:2],2'b00}.
    - On m_ready: install m_rdata, tag, valid=1, dirty=0 → IDLE.
    - The request then hits the following cycle. Fill without a CPU request (cannot occur) returns to IDLE.
- m_readM/m_writeM are registered: asserted on entry to FILL/WB, deasserted in the cycle after m_ready. They are never both high.
- m_ready outside WB/FILL is ignored.
- Miss latency = WB memory latency (if dirty) + FILL latency + 1 cycle.
- Counters wrap at 16'hFFFF→0.
- Request dropped mid-miss (CPU misbehaving): the in-progress memory transaction still completes; no counter update.

Test Plan:
- Cold read 0x0013 after reset:
  - c_wait high, m_readM with m_address=0x0010.
  - m_ready with m_rdata=64'h4444_3333_2222_1111 → next cycle c_rdata=16'h4444, c_wait low, access=1, hit=0.
- Read 0x0011 right after → same-cycle c_wait=0, c_rdata=16'h2222, hit=1, access=2.
- Write 0xABCD to 0x0012, then fill lines 0x0020, 0x0030, 0x0040, then miss on 0x0050:
  - m_writeM with m_address=0x0010 and m_wdata=64'h4444_ABCD_2222_1111.
  - Then m_readM with m_address=0x0050.
- LRU: fill 4 lines A..D, re-read A, miss on E → line B evicted (B's tag absent, A still hits).
- Reset asserted mid-FILL (m_ready not yet seen) → next cycle m_readM=0, all lines invalid, counters 0, c_wait high for any pending request.
- c_readM and c_writeM both high on hit 0x0011 with c_wdata=0x5555 → word written. Subsequent read returns 0x5555.
